// File: rtl/reg_write_port.sv
// reg_write_port: merges the MEM/WB stream and a buffered multi-cycle producer onto the register-file write port
module reg_write_port #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_rd,
    input  logic [31:0] mc_data,
    output logic        regWrite,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic        pipe_hold,
    input  logic [4:0]  q_rs1,
    input  logic [4:0]  q_rs2,
    output logic        q_hit1,
    output logic        q_hit2,
    output logic [31:0] q_data1,
    output logic [31:0] q_data2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    rd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;
    logic [AW-1:0] idx;
    logic          pipe_go;
    logic          pop;
    logic          push;

    // The pipe always wins; rd=0 on either source is a discarded write.
    assign pipe_go   = pipe_valid && (pipe_rd != 5'd0);
    assign pop       = !pipe_go && (count != '0);
    assign mc_ready  = !rst && (count < CW'(DEPTH));
    assign push      = mc_valid && mc_ready && (mc_rd != 5'd0);
    assign pipe_hold = (starve == SW'(STARVE_LIMIT));

    // FIFO bookkeeping and starvation counter; reset drops all buffered entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            count  <= count + CW'(push) - CW'(pop);
            starve <= (pop || count == '0) ? '0 : (pipe_hold ? starve : starve + SW'(1));
        end
    end

    // Entry storage needs no reset: validity comes from count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= mc_rd;
            data_mem[wr_ptr] <= mc_data;
        end
    end

    // Registered write port; address and data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite <= 1'b0;
            A3       <= '0;
            WD       <= '0;
        end else begin
            regWrite <= pipe_go || pop;
            A3       <= pipe_go ? pipe_rd : (pop ? rd_mem[rd_ptr] : A3);
            WD       <= pipe_go ? pipe_data : (pop ? data_mem[rd_ptr] : WD);
        end
    end

    // Hazard lookup, oldest to youngest so the youngest match overrides.
    always_comb begin
        q_hit1  = 1'b0;
        q_hit2  = 1'b0;
        q_data1 = '0;
        q_data2 = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + AW'(i);
            if (CW'(i) < count) begin
                if (q_rs1 != 5'd0 && rd_mem[idx] == q_rs1) begin
                    q_hit1  = 1'b1;
                    q_data1 = data_mem[idx];
                end
                if (q_rs2 != 5'd0 && rd_mem[idx] == q_rs2) begin
                    q_hit2  = 1'b1;
                    q_data2 = data_mem[idx];
                end
            end
        end
    end
endmodule

// File: doc/reg_write_port.md
# reg_write_port

Write-side front end of the pipeline register file: it owns the single write port (regWrite, A3, WD) and merges two result producers onto it. The in-order MEM/WB stream always wins and is never stalled. A multi-cycle unit (divider or long-latency load) hands results over through a valid/ready handshake and waits in a small FIFO. The block also answers hazard lookups against buffered results and requests a pipeline bubble when the FIFO starves.

## Interface
- DEPTH, 4: FIFO entries for multi-cycle results; power of two, at least 2.
- STARVE_LIMIT, 8: consecutive cycles a non-empty FIFO may go unserved before pipe_hold asserts; at least 1.

- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- pipe_valid  input  1  MEM/WB result valid this cycle.
- pipe_rd  input  5  MEM/WB destination register.
- pipe_data  input  32  MEM/WB result.
- mc_valid  input  1  multi-cycle result offered.
- mc_ready  output  1  block accepts the mc result this cycle.
- mc_rd  input  5  multi-cycle destination register.
- mc_data  input  32  multi-cycle result.
- regWrite  output  1  register-file write enable (registered).
- A3  output  5  register-file write address (registered).
- WD  output  32  register-file write data (registered).
- pipe_hold  output  1  request to the hazard unit: present no pipe_valid next cycle.
- q_rs1, q_rs2  input  5 each  decode-stage source registers to check.
- q_hit1, q_hit2  output  1 each  the source matches a buffered FIFO entry.
- q_data1, q_data2  output  32 each  data of the youngest matching entry; 0 when no hit.

## Operation
- Port select each cycle, decided on the current state:
  - if pipe_valid and pipe_rd != 0, the pipe result drives the next regWrite/A3/WD;
  - otherwise, if the FIFO is non-empty, the head is popped and drives them;
  - otherwise regWrite=0 and A3/WD hold their previous values.
- Writes with rd = 0 are discarded at input:
  - pipe: treated as idle, so the FIFO may pop that cycle;
  - mc: handshake still completes (mc_ready honoured), but nothing is pushed.
- mc_ready = !rst && (count < DEPTH), where count is the value before this cycle's pop. A full FIFO never accepts, even if it pops in the same cycle.
- Push happens when mc_valid && mc_ready && mc_rd != 0. Push and pop in the same cycle leave count unchanged.
- There is no bypass from mc input to the port. An entry is pushed at edge t and is eligible for pop from cycle t+1.
- Starve counter:
  - increments each cycle the FIFO is non-empty and not popped, saturating at STARVE_LIMIT;
  - clears on any pop or when the FIFO is empty;
  - pipe_hold = (counter == STARVE_LIMIT), combinational from the counter.
  - If pipe_valid arrives despite pipe_hold, the pipe still wins and the counter stays saturated.
- Hazard lookup is combinational over valid FIFO entries only. Entries whose rd == q_rsN (q_rsN != 0) match, and the youngest match supplies q_dataN. The popped head still counts as buffered in its pop cycle.
- No write-after-write ordering between sources is enforced. The hazard unit uses q_hit to stall decode.
- The FIFO is a circular buffer: rd_ptr and wr_ptr are log2(DEPTH) bits, wrap modulo DEPTH, and count is log2(DEPTH)+1 bits.

## Timing
- Reset values (async, immediate): regWrite=0, A3=0, WD=0, pipe_hold=0, mc_ready=0, q_hit*=0, q_data*=0, FIFO empty, starve counter 0.
- After rst deasserts, mc_ready=1 in the first cycle.
- Reset mid-operation drops all buffered entries; no partial write is issued.
- Pipe latency: 1 edge. Inputs sampled at edge t appear on regWrite/A3/WD after edge t. The register file commits on the following negedge, before the decode read in the second half-cycle.
- mc latency: accepted at edge t, earliest on the port after edge t+1.
- pipe_hold rises in the cycle after the STARVE_LIMIT-th unserved cycle and falls the cycle after the pop.

## Test plan
- Reset: assert rst mid-cycle with 2 entries buffered -> all outputs 0 immediately; after release mc_ready=1 and no write is ever issued for the dropped entries.
- Pipe only: pipe_valid with rd=5, data=0xDEADBEEF at edge t -> regWrite=1, A3=5, WD=0xDEADBEEF after edge t; rd=0 -> regWrite=0.
- FIFO fill: pipe_valid held high, mc pushes rd=1..4 with data 0x11..0x44 -> mc_ready=0 after the 4th push; when pipe goes idle, writes drain in order 1,2,3,4, one per cycle, and mc_ready returns to 1 after the first pop.
- Starvation: DEPTH=4, STARVE_LIMIT=3, one entry buffered and pipe_valid continuous -> pipe_hold=1 after 3 unserved cycles; pipe idles one cycle -> entry written and pipe_hold=0 the next cycle.
- Hazard lookup: FIFO holds rd=7/0xA then rd=7/0xB, with q_rs1=7 and q_rs2=0 -> q_hit1=1, q_data1=0xB, q_hit2=0, q_data2=0.
- x0 handling: mc_valid with mc_rd=0 while mc_ready=1 -> handshake completes, count unchanged, no regWrite.
